// File: rtl/serial_addsub_pkg.sv
// Shared types and op encodings for the bit-serial add/subtract sequencer.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_fas.sv
// One-bit full adder/subtractor: a_ns selects a + b + cin or a + ~b + cin.
module fas
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic bEff;

  assign bEff = (a_ns == OP_ADD) ? b : ~b;
  assign s    = a ^ bEff ^ cin;
  assign cout = (a & bEff) | (a & cin) | (bEff & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: streams latched operands LSB-first through
// a single fas cell and shifts the sum bits into the result register.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fasS, fasC;

  fas u_fas (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .a_ns (op_q),
    .s    (fasS),
    .cout (fasC)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    op_d    = op_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          op_d    = op;
          // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
          carry_d = (op == OP_SUB);
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = {fasS, res_q[WIDTH-1:1]};
        carry_d = fasC;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Overflow: carry into the MSB differs from carry out of it.
          cout_d  = fasC;
          ovf_d   = carry_q ^ fasC;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
